// File: rtl/wishbone_spi_slave_regs.sv
// Wishbone classic register slave for the SPI core: TX/RX, CTRL, DIVIDER, SS.
// Generates the shift-engine start pulse and the end-of-transfer interrupt.
module wishbone_spi_slave_regs #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned SS_W  = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [4:0]         adr_in,
    input  logic [31:0]        dat_in,
    input  logic [3:0]         sel_in,
    input  logic               we_in,
    input  logic               cyc_in,
    input  logic               stb_in,
    output logic [31:0]        dat_o,
    output logic               ack_o,
    output logic               err_o,
    output logic               int_o,
    output logic               go_o,
    output logic [13:0]        ctrl_o,
    output logic [DIV_W-1:0]   divider_o,
    output logic [SS_W-1:0]    ss_o,
    output logic [127:0]       tx_o,
    input  logic [127:0]       rx_in,
    input  logic               done_in
);

    localparam int unsigned CTRL_W   = 14;
    localparam int unsigned GO_BIT   = 8;
    localparam int unsigned IE_BIT   = 12;
    localparam int unsigned ASS_BIT  = 13;
    localparam logic [2:0]  A_CTRL   = 3'd4;
    localparam logic [2:0]  A_DIV    = 3'd5;
    localparam logic [2:0]  A_SS     = 3'd6;
    localparam logic [2:0]  A_BAD    = 3'd7;
    // Byte-lane writable CTRL bits; bit 7 is reserved, GO_BSY is set-only.
    localparam logic [CTRL_W-1:0] CTRL_WMASK = 14'h3E7F;

    logic [31:0]            dat_q, dat_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   int_q, int_d;
    logic                   go_q, go_d;
    logic                   go_arm_q, go_arm_d;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [SS_W-1:0]        ss_q, ss_d;
    logic [3:0][31:0]       tx_q, tx_d;

    logic                   req_c;
    logic                   adr_bad_c;
    logic                   term_c;
    logic                   wr_c;
    logic                   rd_c;
    logic                   busy_c;
    logic [31:0]            wmask_c;
    logic [3:0][31:0]       rx_arr_c;

    // Bus decode, register write/read, GO and interrupt handling.
    always_comb begin
        req_c     = cyc_in & stb_in;
        adr_bad_c = (adr_in[4:2] == A_BAD) | (adr_in[1:0] != 2'b00);
        term_c    = req_c & ~ack_q & ~err_q;
        ack_d     = term_c & ~adr_bad_c;
        err_d     = term_c & adr_bad_c;
        wr_c      = ack_d & we_in;
        rd_c      = ack_d & ~we_in;
        busy_c    = ctrl_q[GO_BIT];
        wmask_c   = {{8{sel_in[3]}}, {8{sel_in[2]}}, {8{sel_in[1]}}, {8{sel_in[0]}}};
        rx_arr_c  = rx_in;

        dat_d     = 32'h0;
        int_d     = int_q;
        go_arm_d  = 1'b0;
        go_d      = go_arm_q;
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        ss_d      = ss_q;
        tx_d      = tx_q;

        if (wr_c) begin
            case (adr_in[4:2])
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    if (!busy_c) begin
                        tx_d[adr_in[3:2]] = (tx_q[adr_in[3:2]] & ~wmask_c) | (dat_in & wmask_c);
                    end
                end
                A_CTRL: begin
                    if (!busy_c) begin
                        ctrl_d = (ctrl_q & ~(wmask_c[CTRL_W-1:0] & CTRL_WMASK))
                               | (dat_in[CTRL_W-1:0] & wmask_c[CTRL_W-1:0] & CTRL_WMASK);
                        if (sel_in[1] && dat_in[GO_BIT]) begin
                            ctrl_d[GO_BIT] = 1'b1;
                            go_arm_d       = 1'b1;
                        end
                    end
                end
                A_DIV: begin
                    if (!busy_c) begin
                        div_d = (div_q & ~wmask_c[DIV_W-1:0]) | (dat_in[DIV_W-1:0] & wmask_c[DIV_W-1:0]);
                    end
                end
                A_SS: begin
                    ss_d = (ss_q & ~wmask_c[SS_W-1:0]) | (dat_in[SS_W-1:0] & wmask_c[SS_W-1:0]);
                end
                default: ;
            endcase
        end

        if (rd_c) begin
            case (adr_in[4:2])
                3'd0, 3'd1, 3'd2, 3'd3: dat_d = rx_arr_c[adr_in[3:2]];
                A_CTRL:                 dat_d = 32'(ctrl_q);
                A_DIV:                  dat_d = 32'(div_q);
                A_SS:                   dat_d = 32'(ss_q);
                default:                dat_d = 32'h0;
            endcase
        end

        // Completion only counts while busy; a same-cycle discarded write stays discarded.
        if (done_in && busy_c) begin
            ctrl_d[GO_BIT] = 1'b0;
        end

        // Any acked access clears the interrupt; a new completion wins.
        if (ack_d) begin
            int_d = 1'b0;
        end
        if (done_in && busy_c && ctrl_q[IE_BIT]) begin
            int_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dat_q    <= 32'h0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            int_q    <= 1'b0;
            go_q     <= 1'b0;
            go_arm_q <= 1'b0;
            ctrl_q   <= '0;
            div_q    <= '1;
            ss_q     <= '0;
            tx_q     <= '0;
        end else begin
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            int_q    <= int_d;
            go_q     <= go_d;
            go_arm_q <= go_arm_d;
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            ss_q     <= ss_d;
            tx_q     <= tx_d;
        end
    end

    // Output mapping; automatic slave select only drives lines during a transfer.
    always_comb begin
        dat_o     = dat_q;
        ack_o     = ack_q;
        err_o     = err_q;
        int_o     = int_q;
        go_o      = go_q;
        ctrl_o    = ctrl_q;
        divider_o = div_q;
        tx_o      = tx_q;
        ss_o      = ctrl_q[ASS_BIT] ? (ss_q & {SS_W{ctrl_q[GO_BIT]}}) : ss_q;
    end

endmodule

// File: tb/tb_wishbone_spi_slave_regs.sv
// Directed self-checking bench for wishbone_spi_slave_regs.
module tb_wishbone_spi_slave_regs;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic [4:0]   adr_in = '0;
    logic [31:0]  dat_in = '0;
    logic [3:0]   sel_in = '0;
    logic         we_in = 1'b0;
    logic         cyc_in = 1'b0;
    logic         stb_in = 1'b0;
    logic [31:0]  dat_o;
    logic         ack_o;
    logic         err_o;
    logic         int_o;
    logic         go_o;
    logic [13:0]  ctrl_o;
    logic [15:0]  divider_o;
    logic [7:0]   ss_o;
    logic [127:0] tx_o;
    logic [127:0] rx_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    logic         done_in = 1'b0;

    int checks = 0;
    int failures = 0;

    logic         r_ack;
    logic         r_err;
    logic [31:0]  r_dat;

    wishbone_spi_slave_regs #(.DIV_W(16), .SS_W(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .adr_in(adr_in), .dat_in(dat_in),
        .sel_in(sel_in), .we_in(we_in), .cyc_in(cyc_in), .stb_in(stb_in),
        .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .int_o(int_o), .go_o(go_o),
        .ctrl_o(ctrl_o), .divider_o(divider_o), .ss_o(ss_o), .tx_o(tx_o),
        .rx_in(rx_in), .done_in(done_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One idle cycle, then a single access; returns at 1ns after the terminating edge.
    task automatic bus(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input logic done);
        @(posedge clk_in); #1;
        adr_in = adr; dat_in = dat; sel_in = sel; we_in = we;
        cyc_in = 1'b1; stb_in = 1'b1; done_in = done;
        @(posedge clk_in); #1;
        r_ack = ack_o; r_err = err_o; r_dat = dat_o;
        cyc_in = 1'b0; stb_in = 1'b0; done_in = 1'b0; we_in = 1'b0;
    endtask

    initial begin
        // Reset state
        rst_in = 1'b1;
        #1;
        chk("rst_ack", 128'(ack_o), 128'h0);
        chk("rst_err", 128'(err_o), 128'h0);
        chk("rst_int", 128'(int_o), 128'h0);
        chk("rst_go", 128'(go_o), 128'h0);
        chk("rst_dat", 128'(dat_o), 128'h0);
        chk("rst_ctrl", 128'(ctrl_o), 128'h0);
        chk("rst_tx", tx_o, 128'h0);
        chk("rst_ss", 128'(ss_o), 128'h0);
        chk("rst_div", 128'(divider_o), 128'hFFFF);
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_in = 1'b0;

        // DIVIDER reset value reads back zero-extended
        bus(5'h14, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("div_rd_ack", 128'(r_ack), 128'h1);
        chk("div_rd_dat", 128'(r_dat), 128'h0000FFFF);

        // Partial byte-lane write to TX1
        bus(5'h04, 32'hA5A5A5A5, 4'b0011, 1'b1, 1'b0);
        chk("tx1_ack", 128'(r_ack), 128'h1);
        chk("tx1_val", 128'(tx_o[63:32]), 128'h0000A5A5);
        chk("tx0_val", 128'(tx_o[31:0]), 128'h0);
        @(posedge clk_in); #1;
        chk("tx1_ack_drop", 128'(ack_o), 128'h0);

        // RX1 read
        bus(5'h04, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("rx1_dat", 128'(r_dat), 128'h22222222);

        // Error terminations
        bus(5'h1C, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("err1c_err", 128'(r_err), 128'h1);
        chk("err1c_ack", 128'(r_ack), 128'h0);
        chk("err1c_dat", 128'(r_dat), 128'h0);
        @(posedge clk_in); #1;
        chk("err1c_drop", 128'(err_o), 128'h0);
        bus(5'h13, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
        chk("err13_err", 128'(r_err), 128'h1);
        chk("err13_ack", 128'(r_ack), 128'h0);
        chk("err13_ctrl", 128'(ctrl_o), 128'h0);
        bus(5'h13, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("err13r_err", 128'(r_err), 128'h1);

        // DIVIDER low byte, SS write
        bus(5'h14, 32'h12345678, 4'b0001, 1'b1, 1'b0);
        chk("div_wr", 128'(divider_o), 128'hFF78);
        bus(5'h18, 32'h00000005, 4'b0001, 1'b1, 1'b0);
        chk("ss_noass", 128'(ss_o), 128'h05);

        // CTRL with ASS, bit 7 ignored
        bus(5'h10, 32'h000020FF, 4'b0011, 1'b1, 1'b0);
        chk("ctrl_ass", 128'(ctrl_o), 128'h207F);
        chk("ss_ass_idle", 128'(ss_o), 128'h00);

        // GO with IE, ASS, LEN=8
        bus(5'h10, 32'h00003108, 4'b0011, 1'b1, 1'b0);
        chk("go_ctrl", 128'(ctrl_o), 128'h3108);
        chk("go_not_yet", 128'(go_o), 128'h0);
        chk("ss_ass_busy", 128'(ss_o), 128'h05);
        @(posedge clk_in); #1;
        chk("go_pulse", 128'(go_o), 128'h1);
        @(posedge clk_in); #1;
        chk("go_end", 128'(go_o), 128'h0);

        // Writes discarded while busy; SS stays writable
        bus(5'h00, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
        chk("busy_tx_ack", 128'(r_ack), 128'h1);
        chk("busy_tx", 128'(tx_o[31:0]), 128'h0);
        bus(5'h14, 32'h0, 4'hF, 1'b1, 1'b0);
        chk("busy_div", 128'(divider_o), 128'hFF78);
        bus(5'h10, 32'h0, 4'hF, 1'b1, 1'b0);
        chk("busy_ctrl", 128'(ctrl_o), 128'h3108);
        bus(5'h18, 32'h00000007, 4'b0001, 1'b1, 1'b0);
        chk("busy_ss", 128'(ss_o), 128'h07);

        // Transfer completion
        done_in = 1'b1;
        @(posedge clk_in); #1;
        done_in = 1'b0;
        chk("done_ctrl", 128'(ctrl_o), 128'h3008);
        chk("done_int", 128'(int_o), 128'h1);
        chk("done_ss", 128'(ss_o), 128'h00);

        // Completion while idle is ignored
        done_in = 1'b1;
        @(posedge clk_in); #1;
        done_in = 1'b0;
        chk("idle_done_ctrl", 128'(ctrl_o), 128'h3008);
        chk("idle_done_int", 128'(int_o), 128'h1);

        // Acked read clears interrupt
        bus(5'h10, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("ctrl_rd", 128'(r_dat), 128'h3008);
        chk("int_clr", 128'(int_o), 128'h0);

        // Completion coincident with a discarded write
        bus(5'h10, 32'h00003108, 4'b0010, 1'b1, 1'b0);
        chk("go2_ctrl", 128'(ctrl_o[8]), 128'h1);
        bus(5'h00, 32'h11111111, 4'hF, 1'b1, 1'b1);
        chk("coinc_tx", 128'(tx_o[31:0]), 128'h0);
        chk("coinc_gobsy", 128'(ctrl_o[8]), 128'h0);
        chk("coinc_int", 128'(int_o), 128'h1);

        // Strobe held four cycles: no back-to-back ack
        @(posedge clk_in); #1;
        adr_in = 5'h14; we_in = 1'b0; sel_in = 4'h0; cyc_in = 1'b1; stb_in = 1'b1;
        chk("hold_ack0", 128'(ack_o), 128'h0);
        @(posedge clk_in); #1;
        chk("hold_ack1", 128'(ack_o), 128'h1);
        @(posedge clk_in); #1;
        chk("hold_ack2", 128'(ack_o), 128'h0);
        @(posedge clk_in); #1;
        chk("hold_ack3", 128'(ack_o), 128'h1);
        cyc_in = 1'b0; stb_in = 1'b0;

        // Mid-cycle reset drops ack immediately
        @(posedge clk_in); @(posedge clk_in); #1;
        adr_in = 5'h14; cyc_in = 1'b1; stb_in = 1'b1;
        @(posedge clk_in); #1;
        chk("mid_ack_pre", 128'(ack_o), 128'h1);
        rst_in = 1'b1;
        #1;
        chk("mid_ack_rst", 128'(ack_o), 128'h0);
        chk("mid_div_rst", 128'(divider_o), 128'hFFFF);
        cyc_in = 1'b0; stb_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        bus(5'h14, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("retry_dat", 128'(r_dat), 128'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
